// File: rtl/axi_mem_responder_if.sv
// AXI4 (with ATOP) channel bundle between the core's initiator and the memory
// responder. Signal suffixes are seen from the responder: _i driven by the
// initiator, _o driven by the responder.
interface axi_mem_responder_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4
);
    logic                   aw_valid_i;
    logic                   aw_ready_o;
    logic [IdWidth-1:0]     aw_id_i;
    logic [AddrWidth-1:0]   aw_addr_i;
    logic [7:0]             aw_len_i;
    logic [2:0]             aw_size_i;
    logic [1:0]             aw_burst_i;
    logic [5:0]             aw_atop_i;

    logic                   w_valid_i;
    logic                   w_ready_o;
    logic [DataWidth-1:0]   w_data_i;
    logic [DataWidth/8-1:0] w_strb_i;
    logic                   w_last_i;

    logic                   b_valid_o;
    logic                   b_ready_i;
    logic [IdWidth-1:0]     b_id_o;
    logic [1:0]             b_resp_o;

    logic                   ar_valid_i;
    logic                   ar_ready_o;
    logic [IdWidth-1:0]     ar_id_i;
    logic [AddrWidth-1:0]   ar_addr_i;
    logic [7:0]             ar_len_i;
    logic [2:0]             ar_size_i;
    logic [1:0]             ar_burst_i;

    logic                   r_valid_o;
    logic                   r_ready_i;
    logic [IdWidth-1:0]     r_id_o;
    logic [DataWidth-1:0]   r_data_o;
    logic [1:0]             r_resp_o;
    logic                   r_last_o;

    modport master (
        output aw_valid_i, aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_atop_i,
        input  aw_ready_o,
        output w_valid_i, w_data_i, w_strb_i, w_last_i,
        input  w_ready_o,
        input  b_valid_o, b_id_o, b_resp_o,
        output b_ready_i,
        output ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
        input  ar_ready_o,
        input  r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
        output r_ready_i
    );

    modport slave (
        input  aw_valid_i, aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_atop_i,
        output aw_ready_o,
        input  w_valid_i, w_data_i, w_strb_i, w_last_i,
        output w_ready_o,
        output b_valid_o, b_id_o, b_resp_o,
        input  b_ready_i,
        input  ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
        output ar_ready_o,
        output r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
        input  r_ready_i
    );
endinterface

// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI4 memory responder for the cached DRAM window.
// Word-addressed array, INCR/WRAP bursts, byte strobes, SLVERR on bad requests
// or out-of-window beats. Atomics are refused with SLVERR on B and on one R beat.
//
// state  | meaning
// IDLE   | accepting AR (priority) or AW
// READ   | streaming R beats of the latched read burst
// WRITE  | consuming W beats until w_last_i
// WRESP  | presenting B
// ARESP  | presenting the single error R beat of an atomic with read data
module axi_mem_responder #(
    parameter int unsigned              AddrWidth = 64,
    parameter int unsigned              DataWidth = 64,
    parameter int unsigned              IdWidth   = 4,
    parameter logic [AddrWidth-1:0]     BaseAddr  = 64'h8000_0000,
    parameter int unsigned              NumWords  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    axi_mem_responder_if.slave bus
);

    localparam int unsigned          NumBytes = DataWidth / 8;
    localparam int unsigned          IdxWidth = $clog2(NumWords);
    localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(NumWords) << 3;
    localparam logic [1:0]           RespOkay = 2'b00;
    localparam logic [1:0]           RespSlvErr = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WRESP,
        S_ARESP
    } state_e;

    state_e                 state_q;
    logic [IdWidth-1:0]     id_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [7:0]             len_q;
    logic [1:0]             burst_q;
    logic [8:0]             cnt_q;
    logic                   req_err_q;
    logic                   atop_rdata_q;
    logic [1:0]             resp_q;
    logic                   r_valid_q;
    logic                   b_valid_q;
    logic                   w_ready_q;

    logic [DataWidth-1:0]   mem_q [NumWords];

    logic [AddrWidth-1:0]   offset;
    logic [IdxWidth-1:0]    idx;
    logic                   beat_err;
    logic                   cnt_in_len;
    logic                   cnt_is_last;
    logic                   mem_we;

    // Request-level legality common to reads and writes: 8-byte beats only,
    // INCR or WRAP, and WRAP lengths of 2/4/8/16 beats.
    function automatic logic req_bad(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'd3) || (burst == 2'b00) || (burst == 2'b11) ||
               ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                       input logic [1:0] burst,
                                                       input logic [7:0] len);
        logic [AddrWidth-1:0] inc;
        logic [AddrWidth-1:0] mask;
        inc  = a + AddrWidth'(8);
        mask = ((AddrWidth'(len) + AddrWidth'(1)) << 3) - AddrWidth'(1);
        if (burst == 2'b10) begin
            return (a & ~mask) | (inc & mask);
        end
        return inc;
    endfunction

    // Beat decode: word index of the registered beat address and its error status.
    always_comb begin
        offset      = addr_q - BaseAddr;
        idx         = offset[IdxWidth+2:3];
        beat_err    = req_err_q || (addr_q < BaseAddr) || (offset >= MemBytes);
        cnt_in_len  = (cnt_q <= {1'b0, len_q});
        cnt_is_last = (cnt_q == {1'b0, len_q});
        mem_we      = (state_q == S_WRITE) && w_ready_q && bus.w_valid_i &&
                      !beat_err && cnt_in_len;
    end

    assign bus.ar_ready_o = (state_q == S_IDLE);
    assign bus.aw_ready_o = (state_q == S_IDLE) && !bus.ar_valid_i;
    assign bus.w_ready_o  = w_ready_q;
    assign bus.b_valid_o  = b_valid_q;
    assign bus.b_id_o     = id_q;
    assign bus.b_resp_o   = resp_q;
    assign bus.r_valid_o  = r_valid_q;
    assign bus.r_id_o     = id_q;
    assign bus.r_last_o   = ((state_q == S_READ) && cnt_is_last) || (state_q == S_ARESP);
    assign bus.r_resp_o   = (((state_q == S_READ) && beat_err) || (state_q == S_ARESP))
                            ? RespSlvErr : RespOkay;
    assign bus.r_data_o   = ((state_q == S_READ) && !beat_err) ? mem_q[idx] : '0;

    // Transaction sequencing and all registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            burst_q      <= '0;
            cnt_q        <= '0;
            req_err_q    <= 1'b0;
            atop_rdata_q <= 1'b0;
            resp_q       <= RespOkay;
            r_valid_q    <= 1'b0;
            b_valid_q    <= 1'b0;
            w_ready_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ar_valid_i) begin
                        id_q         <= bus.ar_id_i;
                        addr_q       <= bus.ar_addr_i;
                        len_q        <= bus.ar_len_i;
                        burst_q      <= bus.ar_burst_i;
                        cnt_q        <= '0;
                        req_err_q    <= req_bad(bus.ar_size_i, bus.ar_burst_i, bus.ar_len_i);
                        atop_rdata_q <= 1'b0;
                        r_valid_q    <= 1'b1;
                        state_q      <= S_READ;
                    end else if (bus.aw_valid_i) begin
                        id_q         <= bus.aw_id_i;
                        addr_q       <= bus.aw_addr_i;
                        len_q        <= bus.aw_len_i;
                        burst_q      <= bus.aw_burst_i;
                        cnt_q        <= '0;
                        req_err_q    <= req_bad(bus.aw_size_i, bus.aw_burst_i, bus.aw_len_i) ||
                                        (bus.aw_atop_i != 6'd0);
                        atop_rdata_q <= bus.aw_atop_i[5];
                        resp_q       <= RespOkay;
                        w_ready_q    <= 1'b1;
                        state_q      <= S_WRITE;
                    end
                end
                S_READ: begin
                    if (bus.r_ready_i) begin
                        if (cnt_is_last) begin
                            r_valid_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            addr_q <= next_addr(addr_q, burst_q, len_q);
                            cnt_q  <= cnt_q + 9'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.w_valid_i) begin
                        // Beats past len are swallowed; the count parks at len+1
                        // so a late w_last still flags the length mismatch.
                        if ((beat_err && cnt_in_len) || (bus.w_last_i && !cnt_is_last)) begin
                            resp_q <= RespSlvErr;
                        end
                        if (cnt_in_len) begin
                            cnt_q  <= cnt_q + 9'd1;
                            addr_q <= next_addr(addr_q, burst_q, len_q);
                        end
                        if (bus.w_last_i) begin
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                            state_q   <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (bus.b_ready_i) begin
                        b_valid_q <= 1'b0;
                        if (atop_rdata_q) begin
                            r_valid_q <= 1'b1;
                            state_q   <= S_ARESP;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_ARESP: begin
                    if (bus.r_ready_i) begin
                        r_valid_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobed byte writes into the backing array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (bus.w_strb_i[b]) begin
                    mem_q[idx][b*8 +: 8] <= bus.w_data_i[b*8 +: 8];
                end
            end
        end
    end

endmodule
